lmsm_sequencer: RTL and testbench

- Micro-sequencer for the Load-Multiple / Store-Multiple (LM/SM) instructions in the 6-stage IITB-RISC pipeline.
- Sits at the Decode→Register-Read boundary.
- Expands one LM/SM instruction into one single-register memory micro-op per set bit of its 8-bit register list.
- While expanding, it drives the `sel` of the downstream register-address and memory-address 2:1 muxes, and stalls fetch/decode until done.

---
 rtl/iitb_risc_pkg.sv | 21 ++
 rtl/lsb_prienc.sv | 22 ++
 rtl/lmsm_sequencer.sv | 110 +++++++++++
 tb/tb_lmsm_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iitb_risc_pkg.sv
// rtl/iitb_risc_pkg.sv - shared IITB-RISC constants for the LM/SM micro-sequencer
package iitb_risc_pkg;

    localparam int NUM_REGS      = 8;
    localparam int REG_IDX_WIDTH = 3;
    localparam int ADDR_WIDTH    = 16;

    // Sequencer state encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    // Opcodes decode compares against to raise start / is_load
    localparam logic [3:0] OPC_LM = 4'b0110;
    localparam logic [3:0] OPC_SM = 4'b0111;

    // Returns 1 when at most one bit of the list is set
    function automatic logic at_most_one_set(input logic [NUM_REGS-1:0] v);
        return (v & (v - NUM_REGS'(1))) == '0;
    endfunction

endpackage

// File: rtl/lsb_prienc.sv
// rtl/lsb_prienc.sv - lowest-set-bit priority encoder with any-set flag
module lsb_prienc #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     in_vec,
    output logic [IDX_W-1:0] idx,
    output logic             any_set
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                idx = IDX_W'(i);
            end
        end
        any_set = |in_vec;
    end

endmodule

// File: rtl/lmsm_sequencer.sv
// rtl/lmsm_sequencer.sv - expands one LM/SM into per-register memory micro-ops
module lmsm_sequencer
    import iitb_risc_pkg::*;
#(
    parameter int ADDR_WIDTH_P    = ADDR_WIDTH,
    parameter int NUM_REGS_P      = NUM_REGS,
    parameter int REG_IDX_WIDTH_P = REG_IDX_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       is_load,
    input  logic [NUM_REGS_P-1:0]      reg_list,
    input  logic [ADDR_WIDTH_P-1:0]    base_addr,
    input  logic                       ready,
    input  logic                       flush,
    output logic                       busy,
    output logic                       stall_fetch,
    output logic                       seq_sel,
    output logic                       uop_valid,
    output logic                       uop_is_load,
    output logic [REG_IDX_WIDTH_P-1:0] uop_reg,
    output logic [ADDR_WIDTH_P-1:0]    uop_addr,
    output logic                       uop_last,
    output logic                       done
);

    logic [0:0]                 state_q, state_d;
    logic [NUM_REGS_P-1:0]      pending_q, pending_d;
    logic [ADDR_WIDTH_P-1:0]    addr_q, addr_d;
    logic                       load_q, load_d;
    logic                       done_q, done_d;

    logic [REG_IDX_WIDTH_P-1:0] enc_idx;
    logic                       enc_any;
    logic                       one_left;

    lsb_prienc #(
        .N     (NUM_REGS_P),
        .IDX_W (REG_IDX_WIDTH_P)
    ) u_prienc (
        .in_vec  (pending_q),
        .idx     (enc_idx),
        .any_set (enc_any)
    );

    assign one_left = (pending_q & (pending_q - NUM_REGS_P'(1))) == '0;

    // Micro-op outputs come from registered state only
    always_comb begin
        busy        = (state_q == ST_ISSUE);
        seq_sel     = busy;
        uop_valid   = busy;
        uop_reg     = busy ? enc_idx : '0;
        uop_addr    = addr_q;
        uop_last    = busy && enc_any && one_left;
        uop_is_load = load_q;
        done        = done_q;
        stall_fetch = busy || (start && (reg_list != '0));
    end

    // Next-state: flush wins, then micro-op acceptance, then a new start
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        addr_d    = addr_q;
        load_d    = load_q;
        done_d    = 1'b0;
        if (flush) begin
            state_d   = ST_IDLE;
            pending_d = '0;
        end else if (state_q == ST_ISSUE) begin
            if (ready) begin
                pending_d = pending_q & ~(NUM_REGS_P'(1) << enc_idx);
                addr_d    = addr_q + ADDR_WIDTH_P'(1);
                if (one_left) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
        end else if (start) begin
            if (reg_list == '0) begin
                done_d = 1'b1;
            end else begin
                state_d   = ST_ISSUE;
                pending_d = reg_list;
                addr_d    = base_addr;
                load_d    = is_load;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            addr_q    <= '0;
            load_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            addr_q    <= addr_d;
            load_q    <= load_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb/tb_lmsm_sequencer.sv - self-checking bench for lmsm_sequencer
module tb_lmsm_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_load, ready, flush;
    logic [7:0]  reg_list;
    logic [15:0] base_addr;
    logic        busy, stall_fetch, seq_sel, uop_valid, uop_is_load, uop_last, done;
    logic [2:0]  uop_reg;
    logic [15:0] uop_addr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lmsm_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_load     (is_load),
        .reg_list    (reg_list),
        .base_addr   (base_addr),
        .ready       (ready),
        .flush       (flush),
        .busy        (busy),
        .stall_fetch (stall_fetch),
        .seq_sel     (seq_sel),
        .uop_valid   (uop_valid),
        .uop_is_load (uop_is_load),
        .uop_reg     (uop_reg),
        .uop_addr    (uop_addr),
        .uop_last    (uop_last),
        .done        (done)
    );

    // Reference model: queue of register indices still to be issued
    int          m_q[$];
    logic [15:0] m_addr;
    logic        m_load;
    logic        m_done;

    typedef struct {
        logic        st, ld;
        logic [7:0]  list;
        logic [15:0] base;
        logic        rdy, fl;
        logic        e_valid;
        logic [2:0]  e_reg;
        logic [15:0] e_addr;
        logic        e_last, e_done, e_stall, e_ld;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic ld, logic [7:0] list, logic [15:0] base,
                                logic rdy, logic ev, logic [2:0] er, logic [15:0] ea,
                                logic el, logic ed, logic es, logic eld);
        vec_t v;
        v.st = st; v.ld = ld; v.list = list; v.base = base; v.rdy = rdy; v.fl = 1'b0;
        v.e_valid = ev; v.e_reg = er; v.e_addr = ea; v.e_last = el;
        v.e_done = ed; v.e_stall = es; v.e_ld = eld;
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic st, logic ld, logic [7:0] list, logic [15:0] base,
                         logic rdy, logic fl);
        start = st; is_load = ld; reg_list = list; base_addr = base;
        ready = rdy; flush = fl;
        #1;
    endtask

    task automatic check_model();
        int valid;
        valid = (m_q.size() > 0);
        check("busy", busy, valid);
        check("seq_sel", seq_sel, valid);
        check("uop_valid", uop_valid, valid);
        check("uop_reg", uop_reg, valid ? m_q[0] : 0);
        check("uop_addr", uop_addr, m_addr);
        check("uop_last", uop_last, m_q.size() == 1);
        check("uop_is_load", uop_is_load, m_load);
        check("done", done, m_done);
        check("stall_fetch", stall_fetch, valid || (start && reg_list != 0));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_addr = '0;
        m_load = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic model_update();
        m_done = 1'b0;
        if (flush) begin
            m_q.delete();
        end else if (m_q.size() > 0) begin
            if (ready) begin
                void'(m_q.pop_front());
                m_addr = m_addr + 16'd1;
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end else if (start) begin
            if (reg_list == 8'h00) begin
                m_done = 1'b1;
            end else begin
                for (int i = 0; i < 8; i++) if (reg_list[i]) m_q.push_back(i);
                m_addr = base_addr;
                m_load = is_load;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic step(logic st, logic ld, logic [7:0] list, logic [15:0] base,
                        logic rdy, logic fl);
        drive(st, ld, list, base, rdy, fl);
        check_model();
        tick();
    endtask

    initial begin
        int accepted[$];
        int valid_seen;
        rst = 1'b1;
        drive(0, 0, 8'h00, 16'h0000, 0, 0);
        model_reset();
        #2;
        check("reset busy", busy, 0);
        check("reset uop_valid", uop_valid, 0);
        check("reset uop_addr", uop_addr, 0);
        check("reset done", done, 0);
        check("reset stall", stall_fetch, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed table: LM A5 @0x0100, then SM 01 @0xFFFF, then SM 03 @0xFFFF (wrap)
        tbl.push_back(mk(1, 1, 8'hA5, 16'h0100, 1, 0, 3'd0, 16'h0000, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 1, 3'd0, 16'h0100, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 1, 3'd2, 16'h0101, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 1, 3'd5, 16'h0102, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 1, 3'd7, 16'h0103, 1, 0, 1, 1));
        tbl.push_back(mk(1, 0, 8'h01, 16'hFFFF, 1, 0, 3'd0, 16'h0104, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 1, 3'd0, 16'hFFFF, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 8'h03, 16'hFFFF, 1, 0, 3'd0, 16'h0000, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 1, 3'd0, 16'hFFFF, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 1, 3'd1, 16'h0000, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 0, 3'd0, 16'h0001, 0, 1, 0, 0));
        foreach (tbl[k]) begin
            drive(tbl[k].st, tbl[k].ld, tbl[k].list, tbl[k].base, tbl[k].rdy, tbl[k].fl);
            check("tbl valid", uop_valid, tbl[k].e_valid);
            check("tbl reg", uop_reg, tbl[k].e_reg);
            check("tbl addr", uop_addr, tbl[k].e_addr);
            check("tbl last", uop_last, tbl[k].e_last);
            check("tbl done", done, tbl[k].e_done);
            check("tbl stall", stall_fetch, tbl[k].e_stall);
            check("tbl is_load", uop_is_load, tbl[k].e_ld);
            check_model();
            tick();
        end

        // FF with ready pattern 1,0,0,1,0,0,...: R0..R7 at base..base+7
        step(1, 1, 8'hFF, 16'h2000, 0, 0);
        for (int c = 0; c < 30 && m_q.size() > 0; c++) begin
            drive(0, 0, 8'h00, 16'h0000, (c % 3) == 0, 0);
            check_model();
            if (uop_valid && ready) begin
                accepted.push_back(uop_reg);
                check("ff addr order", uop_addr, 16'h2000 + accepted.size() - 1);
            end
            tick();
        end
        check("ff count", accepted.size(), 8);
        foreach (accepted[k]) check("ff reg order", accepted[k], k);
        step(0, 0, 8'h00, 16'h0000, 0, 0);

        // Empty list: no micro-op, done the next cycle only
        valid_seen = 0;
        drive(1, 0, 8'h00, 16'h1234, 1, 0);
        check("empty stall", stall_fetch, 0);
        check_model();
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 8'h00, 16'h0000, 1, 0);
            if (uop_valid || busy) valid_seen++;
            check("empty done", done, c == 0);
            check_model();
            tick();
        end
        check("empty no uop", valid_seen, 0);

        // Flush on the 3rd micro-op of F0, then a fresh start right after
        step(1, 1, 8'hF0, 16'h0400, 0, 0);
        step(0, 0, 8'h00, 16'h0000, 1, 0);
        step(0, 0, 8'h00, 16'h0000, 1, 0);
        drive(0, 0, 8'h00, 16'h0000, 1, 1);
        check("flush 3rd reg", uop_reg, 6);
        check_model();
        tick();
        drive(1, 0, 8'h03, 16'h0500, 1, 0);
        check("post flush busy", busy, 0);
        check("post flush done", done, 0);
        check_model();
        tick();
        step(0, 0, 8'h00, 16'h0000, 1, 0);
        step(0, 0, 8'h00, 16'h0000, 1, 0);
        step(0, 0, 8'h00, 16'h0000, 1, 0);

        // Asynchronous reset mid-sequence
        step(1, 1, 8'h3C, 16'h0777, 1, 0);
        step(0, 0, 8'h00, 16'h0000, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst busy", busy, 0);
        check("arst valid", uop_valid, 0);
        check("arst addr", uop_addr, 0);
        check("arst is_load", uop_is_load, 0);
        check("arst reg", uop_reg, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1, 1, 8'h80, 16'h0042, 1, 0);
        drive(0, 0, 8'h00, 16'h0000, 1, 0);
        check("post rst reg", uop_reg, 7);
        check("post rst last", uop_last, 1);
        check_model();
        tick();
        step(0, 0, 8'h00, 16'h0000, 1, 0);

        // Randomised traffic against the model
        for (int c = 0; c < 600; c++) begin
            logic [7:0] l;
            l = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            step($urandom_range(0, 2) == 0, 1'($urandom), l, 16'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
